// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [3:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StCollect,
    StWrite,
    StVerifyRd,
    StVerifyCmp,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs bytes LSB-first into a 32-bit word; word_valid pulses alongside the 4th byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        clr,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q;
  logic [31:0] sr_q;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_q <= 2'd0;
      sr_q  <= 32'd0;
    end else if (take) begin
      cnt_q <= cnt_q + 2'd1;
      sr_q  <= {data, sr_q[31:8]};
    end
  end

  // Combinational so the FSM can enter WRITE on the same edge the last byte lands.
  assign word_valid = take && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = sr_q;

endmodule

// File: rtl/imem_stream_loader.sv
// Streams a length-prefixed byte image into instruction memory, then enables the CPU.
// Optional read-back check of every word is built when LOADER_VERIFY_EN is defined.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  input  logic [31:0] rdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done
);

  localparam int unsigned HdrBits = LEN_BYTES * 8;

  loader_state_e      state_q, state_d;
  logic [HdrBits-1:0] len_q, len_d;
  logic [15:0]        idx_q, idx_d;
  logic [15:0]        words_done_q, words_done_d;
  logic [HdrBits-1:0] len_full;
  logic               last_word;
  logic               take;
  logic               pack_clr;
  logic [31:0]        word;
  logic               word_valid;

  assign len_full  = {s_data, len_q[7:0]};
  assign last_word = (idx_q + 16'd1) == len_q;
  assign take      = s_valid && (state_q == StCollect);

`ifndef LOADER_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;
`endif

  byte_word_packer u_packer (
    .clk        (clk),
    .srst       (srst),
    .clr        (pack_clr),
    .take       (take),
    .data       (s_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      idx_q        <= 16'd0;
      words_done_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      words_done_q <= words_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    words_done_d = words_done_q;
    s_ready      = 1'b0;
    wen_ext      = 1'b0;
    ren_ext      = 1'b0;
    wdata_ext    = 32'd0;
    pack_clr     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StLenLo;
          len_d        = '0;
          idx_d        = 16'd0;
          words_done_d = 16'd0;
          pack_clr     = 1'b1;
        end
      end
      StLenLo: begin
        s_ready = 1'b1;
        if (s_valid) begin
          len_d[7:0] = s_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        s_ready = 1'b1;
        if (s_valid) begin
          len_d = len_full;
          if (len_full == '0)                   state_d = StDone;
          else if (32'(len_full) > MAX_WORDS)   state_d = StError;
          else                                  state_d = StCollect;
        end
      end
      StCollect: begin
        s_ready = 1'b1;
        if (word_valid) state_d = StWrite;
      end
      StWrite: begin
        wen_ext      = 1'b1;
        wdata_ext    = word;
        words_done_d = words_done_q + 16'd1;
`ifdef LOADER_VERIFY_EN
        state_d = StVerifyRd;
`else
        if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = StCollect;
        end
`endif
      end
`ifdef LOADER_VERIFY_EN
      StVerifyRd: begin
        ren_ext = 1'b1;
        state_d = StVerifyCmp;
      end
      StVerifyCmp: begin
        if (rdata_ext != word) begin
          state_d = StError;
        end else if (last_word) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = StCollect;
        end
      end
`endif
      default: state_d = state_q;
    endcase
  end

  // idx only advances when another word follows, so it stays below len.
  assign addr_ext   = BASE_ADDR + 64'(idx_q) * 64'(WORD_BYTES);
  assign done       = (state_q == StDone);
  assign error      = (state_q == StError);
  assign cpu_enable = done;
  assign busy       = !(state_q == StIdle || state_q == StDone || state_q == StError);
  assign words_done = words_done_q;

endmodule
